sum_accum: RTL and testbench

- Downstream consumer of the four-operand 6-bit adder. It accepts that adder's 8-bit sum as a stream over a valid/ready handshake.
- Accumulates a programmable number of consecutive sums (a "frame") into a wider total.
- Presents the total with a sticky overflow flag over an output valid/ready handshake.
- Provides the registered, sequential back-end stage that the purely combinational adder lacks.

---
 rtl/sum_accum_if.sv | 26 ++
 rtl/sum_accum.sv | 93 +++++++++
 tb/tb_sum_accum.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sum_accum_if.sv
// Stream bundle between the four-operand adder, the frame accumulator and its consumer.
// The master side feeds sums and takes totals; the slave side is the accumulator.
interface sum_accum_if #(
   parameter int ACC_W = 10,
   parameter int LEN_W = 4
);
   logic [7:0]       in_sum;
   logic             in_valid;
   logic             in_ready;
   logic [LEN_W-1:0] frame_len;
   logic [ACC_W-1:0] out_total;
   logic             out_ovf;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   modport master (
      output in_sum, in_valid, frame_len, out_ready,
      input  in_ready, out_total, out_ovf, out_valid, busy
   );

   modport slave (
      input  in_sum, in_valid, frame_len, out_ready,
      output in_ready, out_total, out_ovf, out_valid, busy
   );
endinterface

// File: rtl/sum_accum.sv
// Frame accumulator behind the combinational four-operand adder: sums frame_len
// consecutive beats into a wider total with a sticky wrap flag, then holds the result.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// ACC   | frame in progress, adding beats until cnt reaches len
// HOLD  | result presented on out_*, upstream stalled until out_ready
module sum_accum #(
   parameter int ACC_W = 10,
   parameter int LEN_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   sum_accum_if.slave      bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ovf_q, ovf_d;

   logic             in_ready;
   logic             in_acc;
   logic [LEN_W-1:0] len_eff;
   logic [ACC_W:0]   sum_w;

   assign in_ready = !rst && (state_q != HOLD);
   assign in_acc   = bus.in_valid && in_ready;
   // A zero length would never terminate, so it is treated as a single-beat frame.
   assign len_eff  = (bus.frame_len == '0) ? LEN_W'(1) : bus.frame_len;
   assign sum_w    = {1'b0, acc_q} + (ACC_W+1)'(bus.in_sum);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_acc) begin
               len_d   = len_eff;
               acc_d   = ACC_W'(bus.in_sum);
               ovf_d   = 1'b0;
               cnt_d   = LEN_W'(1);
               state_d = (len_eff == LEN_W'(1)) ? HOLD : ACC;
            end
         end
         ACC: begin
            if (in_acc) begin
               acc_d = sum_w[ACC_W-1:0];
               ovf_d = ovf_q | sum_w[ACC_W];
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == len_q) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.busy      = (state_q == ACC);
   assign bus.out_total = acc_q;
   assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_sum_accum.sv
// Bench for sum_accum: directed frames plus random frames, checked every cycle
// against a frame-level model that keeps the accepted beats as a plain integer sum.
module tb_sum_accum;
   localparam int ACC_W = 10;
   localparam int LEN_W = 4;
   localparam int MODV  = 1 << ACC_W;

   logic clk;
   logic rst;
   sum_accum_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

   sum_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // frame model: in_hold, beats taken so far, effective length, running integer sum
   bit m_hold = 0;
   int m_cnt  = 0;
   int m_len  = 0;
   int m_sum  = 0;
   int res_total_q[$];
   int res_ovf_q[$];

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_in_ready", int'(bus.in_ready), 0);
         m_hold = 0;
         m_cnt  = 0;
         m_sum  = 0;
      end else if (m_hold) begin
         chk("hold_out_valid", int'(bus.out_valid), 1);
         chk("hold_in_ready", int'(bus.in_ready), 0);
         chk("hold_busy", int'(bus.busy), 0);
         chk("hold_total", int'(bus.out_total), m_sum % MODV);
         chk("hold_ovf", int'(bus.out_ovf), (m_sum >= MODV) ? 1 : 0);
         if (bus.out_ready) begin
            res_total_q.push_back(m_sum % MODV);
            res_ovf_q.push_back((m_sum >= MODV) ? 1 : 0);
            m_hold = 0;
            m_cnt  = 0;
         end
      end else begin
         chk("run_out_valid", int'(bus.out_valid), 0);
         chk("run_in_ready", int'(bus.in_ready), 1);
         chk("run_busy", int'(bus.busy), (m_cnt > 0) ? 1 : 0);
         if (bus.in_valid) begin
            if (m_cnt == 0) begin
               m_len = (bus.frame_len == 0) ? 1 : int'(bus.frame_len);
               m_sum = 0;
            end
            m_sum += int'(bus.in_sum);
            m_cnt++;
            if (m_cnt == m_len) m_hold = 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v, input int gap);
      bit took;
      bus.in_valid = 1'b0;
      repeat (gap) step();
      bus.in_sum   = 8'(v);
      bus.in_valid = 1'b1;
      took = 0;
      for (int t = 0; t < 300 && !took; t++) begin
         @(negedge clk);
         took = bus.in_ready;
         step();
      end
      if (!took) chk("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic expect_result(input string tag, input int exp_total, input int exp_ovf);
      for (int t = 0; t < 300 && res_total_q.size() == 0; t++) step();
      if (res_total_q.size() == 0) begin
         chk({tag, "_timeout"}, 0, 1);
      end else begin
         chk({tag, "_total"}, res_total_q.pop_front(), exp_total);
         chk({tag, "_ovf"}, res_ovf_q.pop_front(), exp_ovf);
      end
   endtask

   task automatic drain_result();
      for (int t = 0; t < 300 && res_total_q.size() == 0; t++) step();
      if (res_total_q.size() == 0) chk("rand_timeout", 0, 1);
      else begin
         void'(res_total_q.pop_front());
         void'(res_ovf_q.pop_front());
      end
   endtask

   bit rand_ready = 0;
   always @(posedge clk) begin
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      int len, gap;
      rst           = 1'b1;
      bus.in_sum    = '0;
      bus.in_valid  = 1'b0;
      bus.frame_len = '0;
      bus.out_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_total", int'(bus.out_total), 0);
      chk("reset_ovf", int'(bus.out_ovf), 0);
      step();

      // basic frame, latency: out_valid exactly one cycle after the 4th accept
      bus.frame_len = 4'd4;
      send(10, 0); send(20, 0); send(30, 0);
      send(40, 0);
      @(negedge clk);
      chk("basic_latency", int'(bus.out_valid), 1);
      step();
      expect_result("basic", 100, 0);

      bus.frame_len = 4'd5;
      for (int i = 0; i < 5; i++) send(255, 0);
      expect_result("ovf", 251, 1);
      bus.frame_len = 4'd2;
      send(1, 0); send(1, 0);
      expect_result("after_ovf", 2, 0);

      // gaps, then a stalled HOLD with an upstream beat waiting
      bus.frame_len = 4'd3;
      send(7, 0); send(8, 1); send(9, 2);
      bus.out_ready = 1'b0;
      bus.in_sum    = 8'd50;
      bus.in_valid  = 1'b1;
      bus.frame_len = 4'd1;
      repeat (5) begin
         step();
         chk("stall_total", int'(bus.out_total), 24);
      end
      chk("stall_no_result", res_total_q.size(), 0);
      bus.out_ready = 1'b1;
      expect_result("stall", 24, 0);
      send(50, 0);
      expect_result("held_beat", 50, 0);

      bus.frame_len = 4'd0;
      send(200, 0);
      expect_result("len0", 200, 0);
      bus.frame_len = 4'd1;
      send(200, 0);
      expect_result("len1", 200, 0);
      bus.frame_len = 4'd15;
      for (int i = 0; i < 15; i++) send(1, 0);
      expect_result("len15", 15, 0);

      bus.frame_len = 4'd4;
      send(1, 0);
      bus.frame_len = 4'd2;
      send(2, 0); send(3, 0); send(4, 0);
      expect_result("len_change", 10, 0);

      // reset mid-frame leaves no residue
      bus.frame_len = 4'd4;
      send(1, 0); send(2, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.frame_len = 4'd2;
      send(3, 0); send(4, 0);
      expect_result("post_reset", 7, 0);

      bus.frame_len = 4'd2;
      send(5, 0); send(6, 0); send(7, 0); send(8, 0);
      expect_result("b2b_a", 11, 0);
      expect_result("b2b_b", 15, 0);

      rand_ready = 1;
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(0, 15);
         bus.frame_len = 4'(len);
         if (len == 0) len = 1;
         for (int b = 0; b < len; b++) begin
            gap = $urandom_range(0, 2);
            send($urandom_range(0, 255), gap);
            bus.frame_len = 4'($urandom_range(0, 15));
         end
         drain_result();
      end
      rand_ready = 0;
      bus.out_ready = 1'b1;
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
